// File: rtl/stream_credit_tx_pkg.sv
// Shared types for the credit-based link transmitter: counter operation
// decode used by the credit counter and reusable by the receiver side.
package stream_credit_tx_pkg;

  typedef enum logic [1:0] {
    CntHold = 2'd0,
    CntDec  = 2'd1,
    CntInc  = 2'd2
  } cnt_op_e;

  // A simultaneous take and give cancel out, so they decode to a hold.
  function automatic cnt_op_e cnt_op(input logic take, input logic give);
    cnt_op_e op;
    case ({take, give})
      2'b10:   op = CntDec;
      2'b01:   op = CntInc;
      default: op = CntHold;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/stream_credit_tx_if.sv
// Bus bundle for the transmitter: upstream valid/ready stream plus the
// forward beat strobe and the returning credit pulse of the link.
interface stream_credit_tx_if #(
  parameter int DataWidth = 32
);

  logic                 valid_i;
  logic                 ready_o;
  logic [DataWidth-1:0] data_i;
  logic                 valid_o;
  logic [DataWidth-1:0] data_o;
  logic                 credit_i;

  modport slave (
    input  valid_i, data_i, credit_i,
    output ready_o, valid_o, data_o
  );

  modport master (
    output valid_i, data_i, credit_i,
    input  ready_o, valid_o, data_o
  );

endinterface

// File: rtl/stream_credit_counter.sv
// Saturating credit counter with a sticky overflow flag; starts full and
// drops (and flags) any credit returned while already full.
module stream_credit_counter
  import stream_credit_tx_pkg::*;
#(
  parameter int NumCredits = 4,
  parameter int CntWidth   = $clog2(NumCredits + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                take_i,
  input  logic                give_i,
  output logic [CntWidth-1:0] count_o,
  output logic                avail_o,
  output logic                overflow_o
);

  localparam logic [CntWidth-1:0] FullCount = CntWidth'(NumCredits);

  logic [CntWidth-1:0] r_count;
  logic [CntWidth-1:0] w_count_nxt;
  logic                r_overflow;
  logic                w_overflow_nxt;
  cnt_op_e             w_op;

  always_comb begin
    w_op           = cnt_op(take_i, give_i);
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    case (w_op)
      CntDec: w_count_nxt = r_count - CntWidth'(1);
      CntInc: begin
        if (r_count == FullCount) begin
          w_overflow_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count + CntWidth'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count    <= FullCount;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  assign count_o    = r_count;
  assign avail_o    = (r_count != '0);
  assign overflow_o = r_overflow;

endmodule

// File: rtl/stream_credit_tx.sv
// Transmitter end of a credit-based link: accepts upstream beats while credits
// remain and forwards each one, registered, as a single-cycle link strobe.
module stream_credit_tx
  import stream_credit_tx_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int NumCredits = 4,
  parameter int CntWidth   = $clog2(NumCredits + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  stream_credit_tx_if.slave   bus,
  output logic [CntWidth-1:0] credits_o,
  output logic                overflow_o
);

  logic                 w_avail;
  logic                 w_acc;
  logic                 r_valid;
  logic [DataWidth-1:0] r_data;

  // ready comes straight off the counter register, never from valid_i/credit_i.
  assign bus.ready_o = w_avail;
  assign w_acc       = bus.valid_i & w_avail;

  stream_credit_counter #(
    .NumCredits (NumCredits),
    .CntWidth   (CntWidth)
  ) u_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .take_i     (w_acc),
    .give_i     (bus.credit_i),
    .count_o    (credits_o),
    .avail_o    (w_avail),
    .overflow_o (overflow_o)
  );

  // Payload is held between beats so the link data lines stay quiet.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_acc;
      if (w_acc) begin
        r_data <= bus.data_i;
      end
    end
  end

  assign bus.valid_o = r_valid;
  assign bus.data_o  = r_data;

endmodule

// File: tb/tb_stream_credit_tx.sv
// Self-checking bench for stream_credit_tx: directed scenarios followed by
// random traffic, all compared against a credit-arithmetic reference model.
module tb_stream_credit_tx;

  localparam int DataWidth  = 32;
  localparam int NumCredits = 4;
  localparam int CntWidth   = $clog2(NumCredits + 1);

  logic                clk;
  logic                rstN;
  logic [CntWidth-1:0] creditsO;
  logic                overflowO;

  stream_credit_tx_if #(.DataWidth(DataWidth)) bus ();

  stream_credit_tx #(
    .DataWidth  (DataWidth),
    .NumCredits (NumCredits)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .bus        (bus),
    .credits_o  (creditsO),
    .overflow_o (overflowO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: credit count, sticky error, and what the link shows.
  int                   mCredits;
  bit                   mOvf;
  bit                   mValid;
  logic [DataWidth-1:0] mData;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".credits"}, 64'(creditsO), 64'(mCredits));
    checkOutput({tag, ".ready"}, 64'(bus.ready_o), 64'(mCredits != 0));
    checkOutput({tag, ".valid"}, 64'(bus.valid_o), 64'(mValid));
    checkOutput({tag, ".data"}, 64'(bus.data_o), 64'(mData));
    checkOutput({tag, ".overflow"}, 64'(overflowO), 64'(mOvf));
  endtask

  task automatic modelReset();
    mCredits = NumCredits;
    mOvf     = 1'b0;
    mValid   = 1'b0;
    mData    = '0;
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic applyStimulus(input string tag, input bit v,
                               input logic [DataWidth-1:0] d, input bit c);
    bit acc;
    bus.valid_i  = v;
    bus.data_i   = d;
    bus.credit_i = c;
    acc    = v && (mCredits > 0);
    mValid = acc;
    if (acc) mData = d;
    if (acc && !c) begin
      mCredits = mCredits - 1;
    end else if (!acc && c) begin
      if (mCredits == NumCredits) mOvf = 1'b1;
      else mCredits = mCredits + 1;
    end
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  initial begin
    logic [DataWidth-1:0] d;
    bit v;
    bit c;

    rstN         = 1'b0;
    bus.valid_i  = 1'b0;
    bus.data_i   = '0;
    bus.credit_i = 1'b0;
    modelReset();
    #12;
    checkAll("reset");
    @(negedge clk);
    rstN = 1'b1;

    // Burst 0xA0.. with valid held and no credits returning
    for (int i = 0; i < 6; i++) begin
      applyStimulus("burst", 1'b1, DataWidth'(32'hA0 + (i < 4 ? i : 4)), 1'b0);
    end
    checkOutput("burstEmpty", 64'(creditsO), 64'd0);
    checkOutput("burstStall", 64'(bus.ready_o), 64'd0);

    // Single credit releases the pending 0xA4
    applyStimulus("credit1", 1'b1, DataWidth'(32'hA4), 1'b1);
    checkOutput("creditReady", 64'(bus.ready_o), 64'd1);
    applyStimulus("sendA4", 1'b1, DataWidth'(32'hA4), 1'b0);
    checkOutput("beatA4", 64'(bus.data_o), 64'hA4);
    applyStimulus("drain", 1'b0, DataWidth'(32'hA5), 1'b0);

    // Climb to two credits, then steady state with credit and accept together
    applyStimulus("refill", 1'b0, '0, 1'b1);
    applyStimulus("refill", 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus("steady", 1'b1, DataWidth'(32'hB0 + i), 1'b1);
    end
    checkOutput("steadyCredits", 64'(creditsO), 64'd2);
    checkOutput("steadyLast", 64'(bus.data_o), 64'hB9);

    // Full counter: credit plus accept is no overflow, lone credit is
    applyStimulus("refill", 1'b0, '0, 1'b1);
    applyStimulus("refill", 1'b0, '0, 1'b1);
    applyStimulus("fullAcc", 1'b1, DataWidth'(32'hC0), 1'b1);
    checkOutput("fullAccOvf", 64'(overflowO), 64'd0);
    applyStimulus("fullIdle", 1'b0, '0, 1'b1);
    checkOutput("overflowSet", 64'(overflowO), 64'd1);
    applyStimulus("sticky", 1'b0, '0, 1'b0);
    checkOutput("overflowSticky", 64'(overflowO), 64'd1);

    // Asynchronous reset mid-burst at one credit left
    for (int i = 0; i < 3; i++) begin
      applyStimulus("preReset", 1'b1, DataWidth'(32'hD0 + i), 1'b0);
    end
    checkOutput("preResetCredits", 64'(creditsO), 64'd1);
    rstN = 1'b0;
    #1;
    modelReset();
    checkAll("asyncReset");
    bus.valid_i = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus("postReset", 1'b0, DataWidth'(32'hDEAD), 1'b0);
    applyStimulus("postReset", 1'b0, DataWidth'(32'hBEEF), 1'b0);

    // Random traffic with a well-behaved receiver
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = DataWidth'($urandom);
      c = (mCredits < NumCredits) ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus("random", v, d, c);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/stream_credit_tx.md
Name:
stream_credit_tx

Overview:
- Transmitter end of a credit-based point-to-point link.
- Converts a local valid/ready stream into a valid-only forward beat stream, gated by a credit counter. The remote receiver buffers each beat and returns one credit pulse per freed slot.
- Sits at the sender side of long or registered interconnect, where a combinational ready path cannot be closed.
- Pairs with a NumCredits-deep receiver FIFO (spill/FIFO on the far end).

Parameters:
- DataWidth, 32, payload width in bits.
- NumCredits, 4, receiver buffer depth and initial credit count; must be >= 1.
- CntWidth, $clog2(NumCredits+1), credit counter width; derived, not to be overridden.

Ports:
- clk_i  input  1  clock, all logic on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  upstream beat valid.
- ready_o  output  1  upstream ready; high when at least one credit is available.
- data_i  input  DataWidth  upstream payload.
- valid_o  output  1  link beat strobe; exactly one cycle per beat; no backpressure.
- data_o  output  DataWidth  link payload; valid only while valid_o is high.
- credit_i  input  1  credit return pulse from the receiver; one credit per high cycle.
- credits_o  output  CntWidth  current credit count (credit_q).
- overflow_o  output  1  sticky error: credit returned while the counter is already full.

Behaviour:
- Reset values:
  - credit_q = NumCredits.
  - valid_o = 0, data_o = 0, overflow_o = 0.
  - ready_o = 1 after reset, since NumCredits >= 1.
- ready_o = (credit_q != 0). It depends only on a register, with no combinational path from valid_i or credit_i.
- Accept: acc = valid_i & ready_o.
- Output register:
  - valid_o_q <= acc.
  - data_o_q <= data_i when acc; otherwise held (data_o is don't-care while valid_o = 0, but must not toggle).
  - Latency from upstream handshake to link beat: 1 cycle.
  - Throughput: 1 beat/cycle while credits last.
- Credit counter update, per cycle:
  - acc & !credit_i: credit_q - 1.
  - !acc & credit_i: credit_q + 1, unless credit_q == NumCredits; then hold and set overflow_o.
  - acc & credit_i: unchanged. This holds even at credit_q == NumCredits, because acc consumes a credit in the same cycle, so it is no overflow.
  - neither: unchanged.
- A credit returned in cycle N becomes visible on ready_o in cycle N+1. A credit is never used in the same cycle it arrives.
- Zero credits: ready_o = 0; valid_i is ignored and data_i is not sampled. A credit_i pulse restores ready_o the next cycle.
- Counter never underflows, because acc requires credit_q != 0.
- Counter never exceeds NumCredits; an excess credit is dropped and flagged.
- overflow_o stays high until reset.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).
  - Any in-flight valid_o is dropped.
  - The remote receiver must be reset concurrently; the block does no credit resynchronisation.
- Arithmetic: unsigned, CntWidth bits. No wrap-around is permitted.

Decomposition:
- Shared package: none required.
- Payload types are passed as DataWidth; CntWidth is computed locally.
- Optional sub-module: stream_credit_counter (counter, saturation and overflow flag), reusable by the receiver side for occupancy tracking.
- The top level holds the accept logic and the output register.

Test Plan:
- Reset, NumCredits=4 -> credits_o=4, ready_o=1, valid_o=0, overflow_o=0.
- Burst with valid_i held high, data 0xA0..0xA5, no credit_i -> valid_o pulses 4 consecutive cycles with 0xA0..0xA3, each one cycle after its accept; ready_o=0 from the cycle after the 4th accept; credits_o=0; 0xA4 stays pending upstream.
- From credits_o=0, a single credit_i pulse -> ready_o=1 next cycle; 0xA4 accepted; valid_o with 0xA4 one cycle later; credits_o back to 0.
- Steady state at credits_o=2: credit_i and an accept in the same cycle for 10 cycles -> credits_o stays 2; 10 beats out back-to-back, in order.
- At credits_o=4, credit_i pulse with valid_i=0 -> credits_o stays 4, overflow_o=1 and sticky. Same case with valid_i=1 -> credits_o=4, overflow_o stays 0.
- Assert rst_ni mid-burst at credits_o=1 -> valid_o=0 and credits_o=4 immediately, overflow_o cleared, no spurious beat after release.
